// File: rtl/mock_array_edge_collector.sv
// Receive side of the mock-array edge path: words from the array boundary are
// queued in a small FIFO and packed into wide, lane-0-in-LSB output beats.
module mock_array_edge_collector #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*DATA_WIDTH-1:0]   out_data,
   output logic [$clog2(LANES+1)-1:0]    out_count,
   output logic                          out_last
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int IDX_W  = $clog2(LANES);
   localparam int OCNT_W = $clog2(LANES + 1);
   localparam int BEAT_W = LANES * DATA_WIDTH;

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_BLOCKED = 2'd2;

   logic [DATA_WIDTH-1:0] r_fifoData [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_fifoLast;
   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   logic [CNT_W-1:0]      r_occupancy;
   logic                  r_inReady;

   logic [IDX_W-1:0]      r_idx;
   logic [BEAT_W-1:0]     r_acc;
   logic [1:0]            r_state;
   logic                  r_outValid;
   logic [BEAT_W-1:0]     r_outData;
   logic [OCNT_W-1:0]     r_outCount;
   logic                  r_outLast;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_empty;
   logic [DATA_WIDTH-1:0] w_headData;
   logic                  w_headLast;
   logic                  w_headFinal;
   logic                  w_slotFree;
   logic [CNT_W-1:0]      w_occNext;
   logic [BEAT_W-1:0]     w_merged;
   logic [1:0]            w_stateNext;

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_count = r_outCount;
   assign out_last  = r_outLast;

   assign w_push      = in_valid && r_inReady;
   assign w_empty     = (r_occupancy == '0);
   assign w_headData  = r_fifoData[r_rdPtr];
   assign w_headLast  = r_fifoLast[r_rdPtr];
   assign w_headFinal = (r_idx == IDX_W'(LANES - 1)) || w_headLast;
   assign w_slotFree  = !r_outValid || out_ready;

   // A blocked packer can only move when the held beat is taken downstream.
   assign w_pop = !w_empty &&
                  ((r_state == ST_BLOCKED) ? out_ready : (!w_headFinal || w_slotFree));

   always_comb begin
      w_occNext = r_occupancy;
      if (w_push && !w_pop) begin
         w_occNext = r_occupancy + CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_occNext = r_occupancy - CNT_W'(1);
      end
   end

   // Lanes at and above idx are always zero in the accumulator, so dropping the
   // head word into lane idx yields the beat with unused lanes already cleared.
   always_comb begin
      w_merged = r_acc;
      w_merged[r_idx*DATA_WIDTH +: DATA_WIDTH] = w_headData;
   end

   always_comb begin
      w_stateNext = r_state;
      if (w_pop) begin
         w_stateNext = w_headFinal ? ST_EMPTY : ST_PARTIAL;
      end else if (!w_empty && w_headFinal && r_outValid && !out_ready) begin
         w_stateNext = ST_BLOCKED;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifoData[r_wrPtr] <= in_data;
         r_fifoLast[r_wrPtr] <= in_last;
      end
   end

   // in_ready is registered from next occupancy, so out_ready never reaches it combinationally.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_occupancy <= '0;
         r_inReady   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         r_occupancy <= w_occNext;
         r_inReady   <= (w_occNext != CNT_W'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_idx      <= '0;
         r_acc      <= '0;
         r_state    <= ST_EMPTY;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outCount <= '0;
         r_outLast  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
         end
         if (w_pop) begin
            if (w_headFinal) begin
               r_outData  <= w_merged;
               r_outCount <= OCNT_W'(r_idx) + OCNT_W'(1);
               r_outLast  <= w_headLast;
               r_outValid <= 1'b1;
               r_idx      <= '0;
               r_acc      <= '0;
            end else begin
               r_acc <= w_merged;
               r_idx <= r_idx + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mock_array_edge_collector.sv
// Directed bench for mock_array_edge_collector: one task per scenario, each
// comparing the outputs against hand-computed values.
module tb_mock_array_edge_collector;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_count;
   logic        out_last;

   int assertCount = 0;
   int failCount   = 0;

   mock_array_edge_collector #(
      .DATA_WIDTH(8),
      .LANES(4),
      .FIFO_DEPTH(4)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_count(out_count),
      .out_last(out_last)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Offers one word for exactly one edge; callers only use it while in_ready is high.
   task automatic driveWord(input logic [7:0] data, input logic last);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      assertCount++;
      if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL rst_in_ready: got %0b expected 0", in_ready); end
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_out_valid: got %0b expected 0", out_valid); end
      assertCount++;
      if (out_data !== 32'h0) begin failCount++; $display("[TB] FAIL rst_out_data: got %h expected 0", out_data); end
      assertCount++;
      if (out_count !== 3'd0) begin failCount++; $display("[TB] FAIL rst_out_count: got %0d expected 0", out_count); end
      assertCount++;
      if (out_last !== 1'b0) begin failCount++; $display("[TB] FAIL rst_out_last: got %0b expected 0", out_last); end
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      assertCount++;
      if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL rst_release_ready: got %0b expected 1", in_ready); end
   endtask

   task automatic test_full_beat();
      out_ready = 1'b1;
      driveWord(8'h11, 1'b0);
      driveWord(8'h22, 1'b0);
      driveWord(8'h33, 1'b0);
      driveWord(8'h44, 1'b0);
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL t1_early_valid: got %0b expected 0", out_valid); end
      @(posedge clock);
      #1;
      assertCount++;
      if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL t1_valid: got %0b expected 1", out_valid); end
      assertCount++;
      if (out_data !== 32'h44332211) begin failCount++; $display("[TB] FAIL t1_data: got %h expected 44332211", out_data); end
      assertCount++;
      if (out_count !== 3'd4) begin failCount++; $display("[TB] FAIL t1_count: got %0d expected 4", out_count); end
      assertCount++;
      if (out_last !== 1'b0) begin failCount++; $display("[TB] FAIL t1_last: got %0b expected 0", out_last); end
      @(posedge clock);
      #1;
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL t1_drop: got %0b expected 0", out_valid); end
      assertCount++;
      if (out_data !== 32'h44332211) begin failCount++; $display("[TB] FAIL t1_hold_data: got %h expected 44332211", out_data); end
   endtask

   task automatic test_last();
      out_ready = 1'b1;
      driveWord(8'hA1, 1'b0);
      driveWord(8'hA2, 1'b1);
      @(posedge clock);
      #1;
      assertCount++;
      if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL t2_valid: got %0b expected 1", out_valid); end
      assertCount++;
      if (out_data !== 32'h0000A2A1) begin failCount++; $display("[TB] FAIL t2_data: got %h expected 0000a2a1", out_data); end
      assertCount++;
      if (out_count !== 3'd2) begin failCount++; $display("[TB] FAIL t2_count: got %0d expected 2", out_count); end
      assertCount++;
      if (out_last !== 1'b1) begin failCount++; $display("[TB] FAIL t2_last: got %0b expected 1", out_last); end
      // Next beat must start at lane 0 and close once when last lands on lane 3.
      driveWord(8'hB1, 1'b0);
      driveWord(8'hB2, 1'b0);
      driveWord(8'hB3, 1'b0);
      driveWord(8'hB4, 1'b1);
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL t2_gap_valid: got %0b expected 0", out_valid); end
      @(posedge clock);
      #1;
      assertCount++;
      if (out_data !== 32'hB4B3B2B1) begin failCount++; $display("[TB] FAIL t2_lane_data: got %h expected b4b3b2b1", out_data); end
      assertCount++;
      if (out_count !== 3'd4) begin failCount++; $display("[TB] FAIL t2_lane_count: got %0d expected 4", out_count); end
      assertCount++;
      if (out_last !== 1'b1) begin failCount++; $display("[TB] FAIL t2_lane_last: got %0b expected 1", out_last); end
      @(posedge clock);
      #1;
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL t2_single_close: got %0b expected 0", out_valid); end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      driveWord(8'h5A, 1'b1);
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL t6_early_valid: got %0b expected 0", out_valid); end
      @(posedge clock);
      #1;
      assertCount++;
      if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL t6_valid: got %0b expected 1", out_valid); end
      assertCount++;
      if (out_data !== 32'h0000005A) begin failCount++; $display("[TB] FAIL t6_data: got %h expected 0000005a", out_data); end
      assertCount++;
      if (out_count !== 3'd1) begin failCount++; $display("[TB] FAIL t6_count: got %0d expected 1", out_count); end
      assertCount++;
      if (out_last !== 1'b1) begin failCount++; $display("[TB] FAIL t6_last: got %0b expected 1", out_last); end
      @(posedge clock);
      #1;
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL t6_drop: got %0b expected 0", out_valid); end
      assertCount++;
      if (out_count !== 3'd1) begin failCount++; $display("[TB] FAIL t6_hold_count: got %0d expected 1", out_count); end
   endtask

   task automatic test_backpressure();
      logic [31:0] expBeat [3];
      int   sent     = 0;
      int   beats    = 0;
      logic wasReady;
      expBeat[0] = 32'h33323130;
      expBeat[1] = 32'h37363534;
      expBeat[2] = 32'h3B3A3938;
      out_ready = 1'b0;
      for (int c = 0; c < 16; c++) begin
         in_valid = (sent < 12);
         in_data  = 8'(8'h30 + sent);
         in_last  = 1'b0;
         wasReady = in_ready;
         @(posedge clock);
         #1;
         if (in_valid && wasReady) sent++;
      end
      assertCount++;
      if (sent !== 11) begin failCount++; $display("[TB] FAIL t3_accepted: got %0d expected 11", sent); end
      assertCount++;
      if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL t3_full_ready: got %0b expected 0", in_ready); end
      assertCount++;
      if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL t3_held_valid: got %0b expected 1", out_valid); end
      out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (out_valid) begin
            assertCount++;
            if (beats >= 3) begin
               failCount++;
               $display("[TB] FAIL t3_extra_beat: got %h expected none", out_data);
            end else if (out_data !== expBeat[beats]) begin
               failCount++;
               $display("[TB] FAIL t3_beat%0d: got %h expected %h", beats, out_data, expBeat[beats]);
            end
            beats++;
         end
         in_valid = (sent < 12);
         in_data  = 8'(8'h30 + sent);
         wasReady = in_ready;
         @(posedge clock);
         #1;
         if (in_valid && wasReady) sent++;
      end
      in_valid = 1'b0;
      assertCount++;
      if (beats !== 3) begin failCount++; $display("[TB] FAIL t3_beat_total: got %0d expected 3", beats); end
      assertCount++;
      if (sent !== 12) begin failCount++; $display("[TB] FAIL t3_sent_total: got %0d expected 12", sent); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] expBeat;
      int   sent      = 0;
      int   beats     = 0;
      int   drops     = 0;
      int   lastCycle = 0;
      logic wasReady;
      out_ready = 1'b1;
      for (int c = 0; c < 120 && beats < 16; c++) begin
         if (out_valid) begin
            for (int j = 0; j < 4; j++) expBeat[j*8 +: 8] = 8'(4*beats + j);
            assertCount++;
            if (out_data !== expBeat) begin failCount++; $display("[TB] FAIL t4_beat%0d: got %h expected %h", beats, out_data, expBeat); end
            if (beats > 0) begin
               assertCount++;
               if (c - lastCycle !== 4) begin failCount++; $display("[TB] FAIL t4_spacing%0d: got %0d expected 4", beats, c - lastCycle); end
            end
            lastCycle = c;
            beats++;
         end
         in_valid = (sent < 64);
         in_data  = 8'(sent);
         in_last  = 1'b0;
         wasReady = in_ready;
         if (in_valid && !wasReady) drops++;
         @(posedge clock);
         #1;
         if (in_valid && wasReady) sent++;
      end
      in_valid = 1'b0;
      assertCount++;
      if (beats !== 16) begin failCount++; $display("[TB] FAIL t4_beat_total: got %0d expected 16", beats); end
      assertCount++;
      if (drops !== 0) begin failCount++; $display("[TB] FAIL t4_ready_drops: got %0d expected 0", drops); end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      driveWord(8'h61, 1'b0);
      driveWord(8'h62, 1'b0);
      driveWord(8'h63, 1'b0);
      driveWord(8'h64, 1'b0);
      driveWord(8'h65, 1'b0);
      driveWord(8'h66, 1'b0);
      @(posedge clock);
      #1;
      assertCount++;
      if (out_data !== 32'h64636261) begin failCount++; $display("[TB] FAIL t5_held_data: got %h expected 64636261", out_data); end
      reset_n = 1'b0;
      #1;
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL t5_async_valid: got %0b expected 0", out_valid); end
      assertCount++;
      if (out_data !== 32'h0) begin failCount++; $display("[TB] FAIL t5_async_data: got %h expected 0", out_data); end
      assertCount++;
      if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL t5_async_ready: got %0b expected 0", in_ready); end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      assertCount++;
      if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL t5_release_ready: got %0b expected 1", in_ready); end
      out_ready = 1'b1;
      driveWord(8'h71, 1'b0);
      driveWord(8'h72, 1'b0);
      driveWord(8'h73, 1'b0);
      driveWord(8'h74, 1'b0);
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL t5_early_valid: got %0b expected 0", out_valid); end
      @(posedge clock);
      #1;
      assertCount++;
      if (out_data !== 32'h74737271) begin failCount++; $display("[TB] FAIL t5_fresh_data: got %h expected 74737271", out_data); end
      assertCount++;
      if (out_count !== 3'd4) begin failCount++; $display("[TB] FAIL t5_fresh_count: got %0d expected 4", out_count); end
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_full_beat();
      test_last();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      repeat (2) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
